// File: rtl/sha256_msg_pad.sv
// ============================================================================
// Module  : sha256_msg_pad
// Purpose : byte stream -> SHA-256 padded 512-bit blocks with valid/ready
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sha256_msg_pad #(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_block,
  output logic         out_first,
  output logic         out_last
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    EMIT  = 2'd1,
    PADX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [511:0]       blk_q, blk_d;
  logic [5:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               pend_len_q, pend_len_d;
  logic               pend_80_q, pend_80_d;
  logic               first_q, first_d;
  logic               ofirst_q, ofirst_d;
  logic               olast_q, olast_d;
  logic               rdy_en_q;

  logic [LEN_W-1:0]   w_len_inc;
  logic [6:0]         w_k;
  logic [8:0]         w_bpos;
  logic               w_fire_in;
  logic               w_fire_out;

  function automatic logic [63:0] bitlen(input logic [LEN_W-1:0] n);
    return {{(61-LEN_W){1'b0}}, n, 3'b000};
  endfunction

  assign in_ready   = rdy_en_q && (state_q == ACCUM);
  assign out_valid  = (state_q == EMIT);
  assign out_block  = blk_q;
  assign out_first  = ofirst_q;
  assign out_last   = olast_q;

  assign w_len_inc  = len_q + 1'b1;
  assign w_k        = {1'b0, idx_q} + 7'd1;
  assign w_bpos     = 9'd504 - {idx_q, 3'b000};
  assign w_fire_in  = in_valid && in_ready;
  assign w_fire_out = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    idx_d      = idx_q;
    len_d      = len_q;
    pend_len_d = pend_len_q;
    pend_80_d  = pend_80_q;
    first_d    = first_q;
    ofirst_d   = ofirst_q;
    olast_d    = olast_q;
    case (state_q)
      ACCUM: begin
        if (w_fire_in) begin
          blk_d[w_bpos +: 8] = in_data;
          idx_d              = idx_q + 6'd1;
          len_d              = w_len_inc;
          if (in_last) begin
            // Buffer is zero from the last accept, so only 0x80 and length need writing.
            state_d  = EMIT;
            idx_d    = 6'd0;
            ofirst_d = first_q;
            if (w_k <= 7'd55) begin
              blk_d[w_bpos - 9'd8 +: 8] = 8'h80;
              blk_d[63:0]               = bitlen(w_len_inc);
              olast_d                   = 1'b1;
            end else if (w_k <= 7'd63) begin
              blk_d[w_bpos - 9'd8 +: 8] = 8'h80;
              olast_d                   = 1'b0;
              pend_len_d                = 1'b1;
            end else begin
              olast_d    = 1'b0;
              pend_len_d = 1'b1;
              pend_80_d  = 1'b1;
            end
          end else if (w_k == 7'd64) begin
            state_d  = EMIT;
            idx_d    = 6'd0;
            ofirst_d = first_q;
            olast_d  = 1'b0;
          end
        end
      end
      EMIT: begin
        if (w_fire_out) begin
          blk_d    = '0;
          idx_d    = 6'd0;
          ofirst_d = 1'b0;
          olast_d  = 1'b0;
          first_d  = olast_q;
          if (olast_q) begin
            len_d = '0;
          end
          state_d = pend_len_q ? PADX : ACCUM;
        end
      end
      PADX: begin
        blk_d          = '0;
        blk_d[511:504] = pend_80_q ? 8'h80 : 8'h00;
        blk_d[63:0]    = bitlen(len_q);
        ofirst_d       = 1'b0;
        olast_d        = 1'b1;
        pend_len_d     = 1'b0;
        pend_80_d      = 1'b0;
        state_d        = EMIT;
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      blk_q      <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      pend_len_q <= 1'b0;
      pend_80_q  <= 1'b0;
      first_q    <= 1'b1;
      ofirst_q   <= 1'b0;
      olast_q    <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      pend_len_q <= pend_len_d;
      pend_80_q  <= pend_80_d;
      first_q    <= first_d;
      ofirst_q   <= ofirst_d;
      olast_q    <= olast_d;
      rdy_en_q   <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha256_msg_pad.sv
// ============================================================================
// Module  : tb_sha256_msg_pad
// Purpose : randomized self-checking bench against a standard padding model
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_sha256_msg_pad;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [511:0] out_block;
  logic         out_first;
  logic         out_last;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   msg_q[$];
  logic [511:0] exp_blk[$];
  logic         exp_first[$];
  logic         exp_last[$];
  logic [511:0] last_blk;
  int           hold_cycles = 0;
  bit           force_valid = 1'b0;

  always #5 clk = ~clk;

  sha256_msg_pad #(.LEN_W(32)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_first (out_first),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Textbook SHA-256 padding: append 0x80, zero to 56 mod 64, 64-bit bit length.
  function automatic void build_exp();
    int n  = msg_q.size();
    int nb = (n + 8) / 64 + 1;
    logic [7:0]   pad[];
    logic [63:0]  bl;
    logic [511:0] blk;
    pad = new[nb * 64];
    foreach (pad[i]) pad[i] = 8'h00;
    for (int i = 0; i < n; i++) pad[i] = msg_q[i];
    pad[n] = 8'h80;
    bl = {29'd0, 32'(n), 3'b000};
    for (int j = 0; j < 8; j++) pad[nb*64 - 8 + j] = bl[63 - 8*j -: 8];
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk[511 - 8*i -: 8] = pad[b*64 + i];
      exp_blk.push_back(blk);
      exp_first.push_back(b == 0);
      exp_last.push_back(b == nb - 1);
    end
  endfunction

  task automatic drive_loop();
    int  i = 0;
    int  budget = 0;
    int  n = msg_q.size();
    bit  fire;
    while (i < n && budget < 20000) begin
      in_valid = force_valid || ($urandom_range(0, 99) < 75);
      in_data  = msg_q[i];
      in_last  = (i == n - 1);
      fire     = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) i++;
      budget++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (i < n) chk("drive_timeout", 512'(i), 512'(n));
  endtask

  task automatic mon_loop();
    int           nb = exp_blk.size();
    int           got = 0;
    int           budget = 0;
    int           held = 0;
    bit           seen = 1'b0;
    logic [511:0] snap;
    while (got < nb && budget < 20000) begin
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          snap = out_block;
          held = 0;
        end
        if (held < hold_cycles) begin
          out_ready = 1'b0;
          chk("stall_in_ready", 512'(in_ready), 512'(0));
          chk("stall_block", out_block, snap);
          held++;
        end else begin
          out_ready = ($urandom_range(0, 99) < 70);
        end
        if (out_ready) begin
          chk("block", out_block, exp_blk.pop_front());
          chk("first", 512'(out_first), 512'(exp_first.pop_front()));
          chk("last", 512'(out_last), 512'(exp_last.pop_front()));
          last_blk = out_block;
          got++;
          seen = 1'b0;
        end
      end else begin
        out_ready = ($urandom_range(0, 99) < 50);
      end
      @(posedge clk); #1;
      budget++;
    end
    out_ready = 1'b0;
    if (got < nb) chk("mon_timeout", 512'(got), 512'(nb));
    exp_blk.delete();
    exp_first.delete();
    exp_last.delete();
  endtask

  task automatic run_msg();
    build_exp();
    @(posedge clk); #1;
    fork
      drive_loop();
      mon_loop();
    join
    msg_q.delete();
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic load_abc();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_out_first", 512'(out_first), 512'(0));
    chk("rst_out_last", 512'(out_last), 512'(0));
    chk("rst_out_block", out_block, 512'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 512'(in_ready), 512'(1));

    load_abc();
    run_msg();
    chk("abc_const", last_blk, {32'h61626380, 416'h0, 64'h18});

    for (int i = 0; i < 55; i++) msg_q.push_back(8'h41);
    run_msg();
    fill_rand(56);  run_msg();
    fill_rand(64);  run_msg();
    fill_rand(130); run_msg();
    chk("len130_const", last_blk[63:0], 512'(64'h410));

    // Backpressure with input held valid across the block boundary.
    hold_cycles = 10;
    force_valid = 1'b1;
    fill_rand(100);
    run_msg();
    hold_cycles = 0;
    force_valid = 1'b0;

    // Reset partway through a message, then a fresh message.
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 255));
      in_last  = 1'b0;
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    chk("midrst_out_valid", 512'(out_valid), 512'(0));
    chk("midrst_in_ready", 512'(in_ready), 512'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready_rel", 512'(in_ready), 512'(1));
    load_abc();
    run_msg();
    chk("abc_after_rst", last_blk, {32'h61626380, 416'h0, 64'h18});

    for (int t = 0; t < 12; t++) begin
      fill_rand($urandom_range(1, 200));
      run_msg();
    end
    fill_rand(63); run_msg();
    fill_rand(1);  run_msg();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
